// File: rtl/icetap_capture.sv
// icetap capture/trigger engine: qualifies samples against store and trigger
// masks and writes them into a circular record RAM, publishing status.

// Per-signal condition evaluator for one 3-bit mask field.
module icetap_field_match (
  input  logic [2:0] field,
  input  logic       cur,
  input  logic       prev,
  input  logic       prev_valid,
  output logic       hit
);
  // Decode the field against current/previous sample of this bit.
  always_comb begin
    hit = 1'b1;
    case (field)
      3'b001: hit = cur;
      3'b010: hit = ~cur;
      3'b011: hit = prev_valid & ~prev & cur;
      3'b100: hit = prev_valid & prev & ~cur;
      3'b101: hit = prev_valid & (prev ^ cur);
      default: hit = 1'b1;
    endcase
  end
endmodule

module icetap_capture #(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 512,
  parameter int POST_TRIGGER = 256,
  parameter int ADDR_BITS    = $clog2(RECORD_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic [NR_SIGNALS-1:0]   signals_in,
  input  logic [NR_SIGNALS*3-1:0] store_mask,
  input  logic [NR_SIGNALS*3-1:0] trigger_mask,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd,
  output logic                    mem_wr,
  output logic [ADDR_BITS-1:0]    mem_addr,
  output logic [NR_SIGNALS-1:0]   mem_wdata,
  output logic                    status_idle,
  output logic [1:0]              status_state,
  output logic [ADDR_BITS-1:0]    status_start_addr,
  output logic [ADDR_BITS-1:0]    status_trigger_addr,
  output logic [ADDR_BITS-1:0]    status_stop_addr
);
  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, POST = 2'd2} state_t;

  // Last post-trigger write index; unused when POST_TRIGGER is 0.
  localparam logic [ADDR_BITS-1:0] POST_LAST =
    ADDR_BITS'((POST_TRIGGER == 0) ? 0 : POST_TRIGGER - 1);

  state_t                 state, state_nxt;
  logic [ADDR_BITS-1:0]   wr_addr, stop_addr, trig_addr, post_cnt;
  logic                   wrapped, prev_valid;
  logic [NR_SIGNALS-1:0]  prev_q, store_hit, trig_hit;
  logic                   store_ok, trig_ok, is_start, is_abort;
  logic                   wr, trig_set, post_inc, start;

  // One evaluator pair per probed signal.
  for (genvar i = 0; i < NR_SIGNALS; i++) begin : g_sig
    icetap_field_match u_store (
      .field(store_mask[3*i +: 3]), .cur(signals_in[i]), .prev(prev_q[i]),
      .prev_valid(prev_valid), .hit(store_hit[i]));
    icetap_field_match u_trig (
      .field(trigger_mask[3*i +: 3]), .cur(signals_in[i]), .prev(prev_q[i]),
      .prev_valid(prev_valid), .hit(trig_hit[i]));
  end

  assign store_ok = &store_hit;
  assign trig_ok  = &trig_hit;
  assign is_start = cmd_valid && (cmd == 3'h1);
  assign is_abort = cmd_valid && (cmd == 3'h2);

  // Next state and per-cycle write/trigger decisions; abort beats trigger.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    trig_set  = 1'b0;
    post_inc  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: if (is_start) begin
        start     = 1'b1;
        state_nxt = PRE;
      end
      PRE: begin
        if (is_abort) state_nxt = IDLE;
        else if (trig_ok) begin
          wr        = 1'b1;
          trig_set  = 1'b1;
          state_nxt = (POST_TRIGGER == 0) ? IDLE : POST;
        end else if (store_ok) wr = 1'b1;
      end
      POST: begin
        if (is_abort) state_nxt = IDLE;
        else if (store_ok) begin
          wr       = 1'b1;
          post_inc = 1'b1;
          if (post_cnt == POST_LAST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  // Capture datapath: addresses, counters, previous sample and RAM port.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_addr    <= '0;
      stop_addr  <= '0;
      trig_addr  <= '0;
      post_cnt   <= '0;
      wrapped    <= 1'b0;
      prev_q     <= '0;
      prev_valid <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_wr <= wr;
      if (start) begin
        wr_addr    <= '0;
        stop_addr  <= '0;
        post_cnt   <= '0;
        wrapped    <= 1'b0;
        prev_valid <= 1'b0;
      end else if (state != IDLE) begin
        prev_q     <= signals_in;
        prev_valid <= 1'b1;
      end
      if (wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= signals_in;
        stop_addr <= wr_addr;
        wr_addr   <= wr_addr + 1'b1;
        if (wr_addr == '1) wrapped <= 1'b1;
      end
      if (trig_set) trig_addr <= wr_addr;
      if (post_inc) post_cnt  <= post_cnt + 1'b1;
    end
  end

  assign status_idle         = (state == IDLE);
  assign status_state        = state;
  assign status_stop_addr    = stop_addr;
  assign status_trigger_addr = trig_addr;
  assign status_start_addr   = wrapped ? stop_addr + 1'b1 : '0;
endmodule

// File: tb/tb_icetap_capture.sv
// Randomized and directed bench for icetap_capture with a sample-list model.
module tb_icetap_capture;
  localparam int N = 16, D = 512, P = 256, AB = 9;

  logic          clk = 0, reset_ = 0;
  logic [N-1:0]  signals_in = '0;
  logic [3*N-1:0] store_mask = '0, trigger_mask = '0;
  logic          cmd_valid = 0;
  logic [2:0]    cmd = '0;
  logic          mem_wr, status_idle;
  logic [AB-1:0] mem_addr, status_start_addr, status_trigger_addr, status_stop_addr;
  logic [N-1:0]  mem_wdata;
  logic [1:0]    status_state;

  icetap_capture #(.NR_SIGNALS(N), .RECORD_DEPTH(D), .POST_TRIGGER(P)) dut (
    .clk(clk), .reset_(reset_), .signals_in(signals_in), .store_mask(store_mask),
    .trigger_mask(trigger_mask), .cmd_valid(cmd_valid), .cmd(cmd),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .status_idle(status_idle), .status_state(status_state),
    .status_start_addr(status_start_addr), .status_trigger_addr(status_trigger_addr),
    .status_stop_addr(status_stop_addr));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int unsigned smp[$];
  logic [AB+N-1:0] exp_q[$], obs_q[$];
  logic [N-1:0] obs_ram [D];
  int m_trig = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Observed RAM traffic.
  always @(negedge clk) if (reset_ && mem_wr) begin
    obs_q.push_back({mem_addr, mem_wdata});
    obs_ram[mem_addr] <= mem_wdata;
  end

  function automatic bit mask_ok(input logic [3*N-1:0] m, input int unsigned v,
                                 input int unsigned pv, input bit pvld);
    bit ok = 1;
    for (int i = 0; i < N; i++) begin
      bit c = v[i], p = pv[i];
      case (m[3*i +: 3])
        3'b001: ok &= c;
        3'b010: ok &= !c;
        3'b011: ok &= pvld && !p && c;
        3'b100: ok &= pvld && p && !c;
        3'b101: ok &= pvld && (p != c);
        default: ;
      endcase
    end
    return ok;
  endfunction

  function automatic logic [3*N-1:0] exact(input int unsigned v);
    logic [3*N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[3*i +: 3] = v[i] ? 3'b001 : 3'b010;
    return m;
  endfunction

  // Reference: walk the sample list, deciding which samples get stored
  // (the n-th stored sample lands at n mod D) and when the capture ends.
  task automatic model(input int n, output int consumed, output bit done, output int nw);
    bit post = 0;
    int pc = 0;
    exp_q.delete();
    nw = 0; done = 0; consumed = n;
    for (int k = 0; k < n; k++) begin
      bit pv = (k > 0);
      int unsigned prv = pv ? smp[k-1] : 0;
      bit t = mask_ok(trigger_mask, smp[k], prv, pv);
      bit s = mask_ok(store_mask, smp[k], prv, pv);
      bit w = 0, fin = 0;
      if (!post) begin
        if (t) begin w = 1; m_trig = nw % D; post = 1; fin = (P == 0); end
        else if (s) w = 1;
      end else if (s) begin
        w = 1; pc++; fin = (pc == P);
      end
      if (w) begin
        exp_q.push_back({AB'(nw % D), N'(smp[k])});
        nw++;
      end
      if (fin) begin consumed = k + 1; done = 1; return; end
    end
  endtask

  task automatic run(input string tag, input int n, input bit mid_start);
    int cons, nw;
    bit done;
    model(n, cons, done, nw);
    obs_q.delete();
    cmd_valid = 1; cmd = 3'h1; tick;
    cmd_valid = 0;
    for (int k = 0; k < cons; k++) begin
      signals_in = N'(smp[k]);
      cmd_valid = mid_start && (k == 5); cmd = 3'h1;
      tick;
    end
    cmd_valid = 0;
    if (!done) begin
      cmd_valid = 1; cmd = 3'h2; signals_in = N'($urandom); tick;
      cmd_valid = 0;
      chk({tag, "_abort_idle"}, status_idle, 1);
    end
    tick; tick;
    chk({tag, "_idle"}, status_idle, 1);
    chk({tag, "_state"}, status_state, 0);
    chk({tag, "_wr_cnt"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_wr"}, obs_q[i], exp_q[i]);
    chk({tag, "_stop"}, status_stop_addr, nw > 0 ? (nw - 1) % D : 0);
    chk({tag, "_start"}, status_start_addr, nw >= D ? nw % D : 0);
    chk({tag, "_trig"}, status_trigger_addr, m_trig);
  endtask

  function automatic logic [3*N-1:0] rand_mask(input int nf);
    logic [3*N-1:0] m = '0;
    for (int j = 0; j < nf; j++) m[3*$urandom_range(N-1, 0) +: 3] = 3'($urandom);
    return m;
  endfunction

  initial begin
    tick; tick;
    chk("rst_idle", status_idle, 1);
    chk("rst_state", status_state, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_stop", status_stop_addr, 0);
    chk("rst_start", status_start_addr, 0);
    reset_ = 1; tick;

    // Basic capture: trigger on bit 3 high.
    store_mask = '0; trigger_mask = '0; trigger_mask[9 +: 3] = 3'b001;
    smp.delete(); for (int k = 0; k < 300; k++) smp.push_back(k);
    run("basic", 300, 0);
    chk("basic_trig_c", status_trigger_addr, 8);
    chk("basic_stop_c", status_stop_addr, 264);
    chk("basic_ram0", obs_ram[0], 0);
    chk("basic_ram264", obs_ram[264], 264);

    // Wrap: exact trigger on 600.
    trigger_mask = exact(600);
    smp.delete(); for (int k = 0; k < 900; k++) smp.push_back(k);
    run("wrap", 900, 0);
    chk("wrap_trig_c", status_trigger_addr, 88);
    chk("wrap_stop_c", status_stop_addr, 344);
    chk("wrap_start_c", status_start_addr, 345);
    chk("wrap_ram345", obs_ram[345], 345);
    chk("wrap_ram88", obs_ram[88], 600);
    chk("wrap_ram344", obs_ram[344], 856);

    // Sparse store: odd values only, trigger on 9.
    store_mask = '0; store_mask[2:0] = 3'b001; trigger_mask = exact(9);
    smp.delete(); for (int k = 0; k < 600; k++) smp.push_back(k);
    run("sparse", 600, 0);
    chk("sparse_trig_c", status_trigger_addr, 4);
    chk("sparse_ram4", obs_ram[4], 9);
    chk("sparse_ram0", obs_ram[0], 1);

    // Rising edge on bit 2, input held at 4 through START.
    store_mask = '0; trigger_mask = '0; trigger_mask[6 +: 3] = 3'b011;
    signals_in = 4;
    smp.delete(); smp.push_back(4); smp.push_back(0); smp.push_back(4);
    for (int k = 3; k < 300; k++) smp.push_back($urandom_range(16'hffff, 0));
    run("edge", 300, 0);
    chk("edge_trig_c", status_trigger_addr, 2);
    chk("edge_ram2", obs_ram[2], 4);

    // Abort after 20 stores, with a stray START mid-capture.
    trigger_mask = exact(16'hffff);
    smp.delete(); for (int k = 0; k < 20; k++) smp.push_back(k);
    run("abort", 20, 1);
    chk("abort_stop_c", status_stop_addr, 19);
    chk("abort_trig_stale", status_trigger_addr, 2);

    // Randomized masks and samples.
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(700, 40);
      store_mask = rand_mask($urandom_range(3, 0));
      trigger_mask = rand_mask($urandom_range(3, 1));
      smp.delete();
      for (int k = 0; k < n; k++) smp.push_back($urandom_range(16'hffff, 0));
      run($sformatf("rnd%0d", r), n, r[0]);
    end

    // Reset in POST_TRIGGER.
    store_mask = '0; trigger_mask = '0; trigger_mask[9 +: 3] = 3'b001;
    cmd_valid = 1; cmd = 3'h1; tick; cmd_valid = 0;
    for (int k = 0; k < 20; k++) begin signals_in = N'(k); tick; end
    chk("mid_state", status_state, 2);
    chk("mid_mem_wr", mem_wr, 1);
    #1 reset_ = 0; #1;
    chk("rst2_mem_wr", mem_wr, 0);
    chk("rst2_idle", status_idle, 1);
    chk("rst2_trig", status_trigger_addr, 0);
    chk("rst2_stop", status_stop_addr, 0);
    chk("rst2_start", status_start_addr, 0);
    tick; reset_ = 1; tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
